// File: rtl/dual_issue_sched.sv
// Dual-issue scheduler: decides per cycle whether to issue the fetched pair, A only, or nothing,
// tracking load-use hazards, branch resolution and performance counters.
module dual_issue_sched #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             in_valid,
  input  logic [31:0]      i1,
  input  logic [31:0]      i2,
  input  logic             hold,
  input  logic             br_done,
  output logic             issue_a,
  output logic             issue_b,
  output logic [1:0]       pc_adv,
  output logic             we1,
  output logic             we2,
  output logic [4:0]       w1addr,
  output logic [4:0]       w2addr,
  output logic             mem_b,
  output logic             ctrl_a,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic {S_ISSUE, S_WAIT_BR} state_t;

  state_t             state_q, state_d;
  logic               ld_v_q, ld_v_d;
  logic [4:0]         ld_r_q, ld_r_d;
  logic [CNT_W-1:0]   cnt_dual_q, cnt_dual_d;
  logic [CNT_W-1:0]   cnt_stall_q, cnt_stall_d;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dec
      logic [31:0] ins;
      logic [4:0]  rs_f, rt_f, dst;
      logic        rd_rs, rd_rt, is_mem, is_ld, is_ctl, ld_hit;

      assign ins  = (gi == 0) ? i1 : i2;
      assign rs_f = ins[25:21];
      assign rt_f = ins[20:16];

      always_comb begin
        rd_rs  = 1'b0;
        rd_rt  = 1'b0;
        dst    = 5'd0;
        is_mem = 1'b0;
        is_ld  = 1'b0;
        is_ctl = 1'b0;
        case (ins[31:26])
          6'b000000: begin
            rd_rs = 1'b1;
            if (ins[5:0] == 6'b001000) begin
              is_ctl = 1'b1;
            end else begin
              rd_rt = 1'b1;
              dst   = ins[15:11];
            end
          end
          6'b001000: begin rd_rs = 1'b1; dst = rt_f; end
          6'b100011: begin rd_rs = 1'b1; dst = rt_f; is_mem = 1'b1; is_ld = 1'b1; end
          6'b101011: begin rd_rs = 1'b1; rd_rt = 1'b1; is_mem = 1'b1; end
          6'b000100: begin rd_rs = 1'b1; rd_rt = 1'b1; is_ctl = 1'b1; end
          6'b000011: begin dst = 5'd31; is_ctl = 1'b1; end
          default: ;
        endcase
      end

      // ld_r_q is never $0 while ld_v_q is set, so reads of $0 never match
      assign ld_hit = ld_v_q && ((rd_rs && rs_f == ld_r_q) || (rd_rt && rt_f == ld_r_q));
    end
  endgenerate

  logic raw_ab, waw_ab, b_blocked;
  logic iss_a, iss_b;
  logic [1:0] adv;

  assign raw_ab = (g_dec[0].dst != 5'd0) &&
                  ((g_dec[1].rd_rs && g_dec[1].rs_f == g_dec[0].dst) ||
                   (g_dec[1].rd_rt && g_dec[1].rt_f == g_dec[0].dst));
  assign waw_ab = (g_dec[0].dst != 5'd0) && (g_dec[1].dst == g_dec[0].dst);
  assign b_blocked = g_dec[1].is_ctl || raw_ab || waw_ab ||
                     (g_dec[0].is_mem && g_dec[1].is_mem) || g_dec[1].ld_hit;

  always_comb begin
    iss_a       = 1'b0;
    iss_b       = 1'b0;
    adv         = 2'd0;
    state_d     = state_q;
    ld_v_d      = ld_v_q;
    ld_r_d      = ld_r_q;
    cnt_dual_d  = cnt_dual_q;
    cnt_stall_d = cnt_stall_q;
    if (hold) begin
      // A branch resolving during a downstream stall must not be lost
      if (state_q == S_WAIT_BR && br_done) state_d = S_ISSUE;
    end else begin
      ld_v_d = 1'b0;
      case (state_q)
        S_ISSUE: begin
          if (in_valid && !g_dec[0].ld_hit) begin
            iss_a = 1'b1;
            if (g_dec[0].is_ctl) begin
              state_d = S_WAIT_BR;
            end else if (b_blocked) begin
              adv = 2'd1;
            end else begin
              iss_b = 1'b1;
              adv   = 2'd2;
            end
          end
        end
        S_WAIT_BR: if (br_done) state_d = S_ISSUE;
        default: state_d = S_ISSUE;
      endcase
      if (iss_a && g_dec[0].is_ld && g_dec[0].dst != 5'd0) begin
        ld_v_d = 1'b1;
        ld_r_d = g_dec[0].dst;
      end else if (iss_b && g_dec[1].is_ld && g_dec[1].dst != 5'd0) begin
        ld_v_d = 1'b1;
        ld_r_d = g_dec[1].dst;
      end
      if (iss_b) cnt_dual_d = cnt_dual_q + CNT_W'(1);
      if (in_valid && !iss_a) cnt_stall_d = cnt_stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state_q     <= S_ISSUE;
      ld_v_q      <= 1'b0;
      ld_r_q      <= 5'd0;
      cnt_dual_q  <= '0;
      cnt_stall_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_v_q      <= ld_v_d;
      ld_r_q      <= ld_r_d;
      cnt_dual_q  <= cnt_dual_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign issue_a   = iss_a & ~rs;
  assign issue_b   = iss_b & ~rs;
  assign pc_adv    = rs ? 2'd0 : adv;
  assign we1       = issue_a && (g_dec[0].dst != 5'd0);
  assign we2       = issue_b && (g_dec[1].dst != 5'd0);
  assign w1addr    = we1 ? g_dec[0].dst : 5'd0;
  assign w2addr    = we2 ? g_dec[1].dst : 5'd0;
  assign mem_b     = issue_b & g_dec[1].is_mem;
  assign ctrl_a    = issue_a & g_dec[0].is_ctl;
  assign cnt_dual  = rs ? '0 : cnt_dual_q;
  assign cnt_stall = rs ? '0 : cnt_stall_q;

endmodule

// File: tb/tb_dual_issue_sched.sv
// Randomized and directed bench for dual_issue_sched against a register-set based reference model.
module tb_dual_issue_sched;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rs, in_valid, hold, br_done;
  logic [31:0]      i1, i2;
  logic             issue_a, issue_b, we1, we2, mem_b, ctrl_a;
  logic [1:0]       pc_adv;
  logic [4:0]       w1addr, w2addr;
  logic [CNT_W-1:0] cnt_dual, cnt_stall;

  int n_tests = 0;
  int n_fail  = 0;

  dual_issue_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rs(rs), .in_valid(in_valid), .i1(i1), .i2(i2),
    .hold(hold), .br_done(br_done),
    .issue_a(issue_a), .issue_b(issue_b), .pc_adv(pc_adv),
    .we1(we1), .we2(we2), .w1addr(w1addr), .w2addr(w2addr),
    .mem_b(mem_b), .ctrl_a(ctrl_a), .cnt_dual(cnt_dual), .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics as sets of registers read and written
  typedef struct packed {
    logic [31:0] rset;
    logic [31:0] wset;
    logic        mem;
    logic        ld;
    logic        ctl;
  } dec_t;

  function automatic dec_t dec(input logic [31:0] x);
    dec_t r;
    logic [31:0] bs, bt, bd;
    r  = '0;
    bs = 32'(1) << x[25:21];
    bt = 32'(1) << x[20:16];
    bd = 32'(1) << x[15:11];
    case (x[31:26])
      6'h00: if (x[5:0] == 6'h08) begin r.rset = bs; r.ctl = 1'b1; end
             else begin r.rset = bs | bt; r.wset = bd; end
      6'h08: begin r.rset = bs; r.wset = bt; end
      6'h23: begin r.rset = bs; r.wset = bt; r.mem = 1'b1; r.ld = 1'b1; end
      6'h2B: begin r.rset = bs | bt; r.mem = 1'b1; end
      6'h04: begin r.rset = bs | bt; r.ctl = 1'b1; end
      6'h03: begin r.wset = 32'h8000_0000; r.ctl = 1'b1; end
      default: ;
    endcase
    r.wset[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [4:0] idx(input logic [31:0] m);
    logic [4:0] k = 5'd0;
    for (int b = 0; b < 32; b++) if (m[b]) k = 5'(b);
    return k;
  endfunction

  // Reference model state: waiting for branch, set of pending load destinations, counters
  bit          m_wait;
  logic [31:0] m_ldset;
  int          m_cd, m_cs;

  logic       o_ia, o_ib, o_we1, o_we2, o_mb, o_ca;
  logic [1:0] o_adv;
  logic [4:0] o_w1, o_w2;
  int         o_cd, o_cs;

  task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic h, input logic bd);
    dec_t da, db;
    logic ea, eb, go_wait, bubble;
    logic [17:0] exp_out, obs_out;
    int ecd, ecs;
    bit n_wait;
    logic [31:0] n_ld;
    rs = r; in_valid = v; i1 = a; i2 = b; hold = h; br_done = bd;
    da = dec(a);
    db = dec(b);
    ea = 1'b0; eb = 1'b0; go_wait = 1'b0;
    n_wait = m_wait; n_ld = m_ldset;
    ecd = m_cd; ecs = m_cs;
    if (r) begin
      ecd = 0; ecs = 0;
      n_wait = 0; n_ld = '0;
    end else if (h) begin
      if (m_wait && bd) n_wait = 0;
    end else begin
      bubble = (da.rset & m_ldset) != 0;
      if (!m_wait && v && !bubble) begin
        ea = 1'b1;
        if (da.ctl) go_wait = 1'b1;
        else eb = !(db.ctl || (db.rset & da.wset) != 0 || (db.wset & da.wset) != 0 ||
                    (da.mem && db.mem) || (db.rset & m_ldset) != 0);
      end
      if (go_wait) n_wait = 1;
      else if (m_wait && bd) n_wait = 0;
      n_ld = (ea && da.ld) ? da.wset : (eb && db.ld) ? db.wset : '0;
    end
    exp_out = {ea, eb, (ea && !go_wait) ? 2'(int'(ea) + int'(eb)) : 2'd0,
               ea && da.wset != 0, (ea && da.wset != 0) ? idx(da.wset) : 5'd0,
               eb && db.wset != 0, (eb && db.wset != 0) ? idx(db.wset) : 5'd0,
               eb && db.mem, ea && da.ctl};
    @(negedge clk);
    o_ia = issue_a; o_ib = issue_b; o_adv = pc_adv; o_we1 = we1; o_w1 = w1addr;
    o_we2 = we2; o_w2 = w2addr; o_mb = mem_b; o_ca = ctrl_a;
    o_cd = int'(cnt_dual); o_cs = int'(cnt_stall);
    obs_out = {o_ia, o_ib, o_adv, o_we1, o_w1, o_we2, o_w2, o_mb, o_ca};
    chk("outs", 64'(obs_out), 64'(exp_out));
    chk("cnt_dual", 64'(o_cd), 64'(ecd % (1 << CNT_W)));
    chk("cnt_stall", 64'(o_cs), 64'(ecs % (1 << CNT_W)));
    $display("[TB] rs=%0b v=%0b h=%0b bd=%0b i1=%h i2=%h -> ia=%0b ib=%0b adv=%0d w1=%0b/%0d w2=%0b/%0d mb=%0b ca=%0b cd=%0d cs=%0d",
             r, v, h, bd, a, b, o_ia, o_ib, o_adv, o_we1, o_w1, o_we2, o_w2, o_mb, o_ca, o_cd, o_cs);
    @(posedge clk);
    if (!r && !h) begin
      if (eb) m_cd = m_cd + 1;
      if (v && !ea) m_cs = m_cs + 1;
    end else if (r) begin
      m_cd = 0; m_cs = 0;
    end
    m_wait = n_wait; m_ldset = n_ld;
    #1;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [4:0] s, t, d;
    s = 5'($urandom_range(0, 3));
    t = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 11))
      0, 1, 2: return {6'h00, s, t, d, 5'd0, 6'h20};
      3:       return {6'h00, s, 15'd0, 6'h08};
      4, 5:    return {6'h08, s, t, 16'($urandom)};
      6, 7:    return {6'h23, s, t, 16'($urandom)};
      8:       return {6'h2B, s, t, 16'($urandom)};
      9:       return {6'h04, s, t, 16'd1};
      10:      return {6'h03, 26'h10};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  localparam logic [31:0] ADDI1 = 32'h2001_0005, ADDI2 = 32'h2002_0007, ADD3 = 32'h0022_1820;
  localparam logic [31:0] LW4 = 32'h8C24_0000, SW4 = 32'hAC44_0000, BEQ = 32'h1022_0001;
  localparam logic [31:0] JAL = 32'h0C00_0010, NOP = 32'h0000_0000;

  initial begin
    rs = 1'b1; in_valid = 1'b0; hold = 1'b0; br_done = 1'b0; i1 = '0; i2 = '0;
    m_wait = 0; m_ldset = '0; m_cd = 0; m_cs = 0;
    @(posedge clk); #1;
    step(1, 1, ADDI1, ADDI2, 0, 0);
    chk("rst_issue", 64'(o_ia), 64'd0);
    // T1
    step(0, 1, ADDI1, ADDI2, 0, 0);
    chk("t1_ib", 64'(o_ib), 64'd1);
    chk("t1_adv", 64'(o_adv), 64'd2);
    chk("t1_w2", 64'({o_we2, o_w2}), 64'({1'b1, 5'd2}));
    // T2
    step(0, 1, ADDI1, ADD3, 0, 0);
    chk("t1_cd", 64'(o_cd), 64'd1);
    chk("t2_ib", 64'(o_ib), 64'd0);
    chk("t2_adv", 64'(o_adv), 64'd1);
    step(0, 1, ADD3, NOP, 0, 0);
    chk("t2_w1", 64'(o_w1), 64'd3);
    // T3
    step(0, 1, LW4, NOP, 0, 0);
    chk("t3_dual", 64'(o_ib), 64'd1);
    step(0, 1, SW4, NOP, 0, 0);
    chk("t3_bubble", 64'(o_ia), 64'd0);
    step(0, 1, SW4, NOP, 0, 0);
    chk("t3_resume", 64'(o_ia), 64'd1);
    chk("t3_cs", 64'(o_cs), 64'd1);
    // T4
    step(0, 1, BEQ, NOP, 0, 1);
    chk("t4_ctrl", 64'({o_ia, o_ca, o_adv}), 64'({1'b1, 1'b1, 2'd0}));
    for (int k = 0; k < 3; k++) begin
      step(0, 1, ADDI1, ADDI2, 0, 0);
      chk("t4_wait", 64'(o_ia), 64'd0);
    end
    step(0, 1, ADDI1, ADDI2, 0, 1);
    step(0, 1, ADDI1, ADDI2, 0, 0);
    chk("t4_resume", 64'(o_ib), 64'd1);
    // T5
    step(0, 1, LW4, SW4, 0, 0);
    chk("t5_mem", 64'({o_ia, o_ib, o_mb}), 64'({1'b1, 1'b0, 1'b0}));
    step(0, 1, ADDI1, JAL, 0, 0);
    chk("t5_jal", 64'({o_ib, o_adv}), 64'({1'b0, 2'd1}));
    // T6
    step(0, 1, ADDI1, ADDI2, 1, 0);
    chk("t6_hold", 64'({o_ia, o_ib, o_adv, o_we1, o_we2}), 64'd0);
    step(0, 1, BEQ, NOP, 0, 0);
    step(0, 1, BEQ, NOP, 1, 1);
    step(0, 1, ADDI1, ADDI2, 0, 0);
    chk("hold_br", 64'(o_ib), 64'd1);
    step(0, 1, BEQ, NOP, 0, 0);
    step(1, 1, ADDI1, ADDI2, 0, 0);
    step(0, 1, ADDI1, ADDI2, 0, 0);
    chk("t6_rst_cnt", 64'(o_cd), 64'd0);
    chk("t6_rst_iss", 64'(o_ib), 64'd1);
    // Random traffic; narrow counters make wrap-around reachable
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, rnd_ins(), rnd_ins(),
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
